// File: rtl/scan_pkg.sv
// Shared scan-chain definitions: controller state encoding and counter sizing.
package scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_CAPT  = 3'd2,
        S_UNLD  = 3'd3,
        S_FIN   = 3'd4
    } scan_state_e;

    // Bits needed to count 0..n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// N-bit parallel-load serial shift register; load wins over shift.
module scan_shreg #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] d,
    input  logic         sin,
    output logic [N-1:0] q_nxt
);

    logic [N-1:0] q;

    // Next value is exported so the owner can register outputs in the same edge.
    always_comb begin
        if (load)
            q_nxt = d;
        else if (shift)
            q_nxt = {q[N-2:0], sin};
        else
            q_nxt = q;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
            q <= '0;
        else
            q <= q_nxt;
    end

endmodule

// File: rtl/scan_chain_ctl.sv
// Scan chain controller: exchange or load-capture-unload of an N-bit chain.
module scan_chain_ctl
    import scan_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         START,
    input  logic         CAP,
    input  logic [N-1:0] LOAD_DATA,
    input  logic         SCANRET,
    output logic         TEST,
    output logic         SCANOUT,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] UNLOAD_DATA
);

    localparam int CW = cnt_width(N);

    scan_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_d;
    logic          cap_q, last;
    logic          sr_load, sr_shift;
    logic          test_d, scanout_d, busy_d, done_d;
    logic [N-1:0]  sr_nxt;

    assign last = (cnt == CW'(N - 1));

    scan_shreg #(.N(N)) u_sr (
        .CLK   (CLK),
        .CLR   (CLR),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (LOAD_DATA),
        .sin   (SCANRET),
        .q_nxt (sr_nxt)
    );

    // Outputs are registered from the next state, so each one is valid in the
    // cycle its state is occupied and nothing downstream sees decode glitches.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cap_q       <= 1'b0;
            TEST        <= 1'b0;
            SCANOUT     <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            UNLOAD_DATA <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_d;
            TEST    <= test_d;
            SCANOUT <= scanout_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            if (sr_load)
                cap_q <= CAP;
            if (state_n == S_FIN)
                UNLOAD_DATA <= sr_nxt;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (START) state_n = S_SHIFT;
            S_SHIFT: if (last)  state_n = cap_q ? S_CAPT : S_FIN;
            S_CAPT:  state_n = S_UNLD;
            S_UNLD:  if (last)  state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        sr_load   = (state == S_IDLE) && START;
        sr_shift  = (state == S_SHIFT) || (state == S_UNLD);
        cnt_d     = (sr_shift && !last) ? cnt + CW'(1) : '0;
        test_d    = (state_n == S_SHIFT) || (state_n == S_UNLD);
        // Only SHIFT drives pattern bits; UNLD zero-fills the chain.
        scanout_d = (state_n == S_SHIFT) ? sr_nxt[N-1] : 1'b0;
        busy_d    = (state_n != S_IDLE);
        done_d    = (state_n == S_FIN);
    end

endmodule

// File: doc/scan_chain_ctl.md
SCAN_CHAIN_CTL -- requirements
Module: scan_chain_ctl

Interface
REQ-001 Parameter N, default 8, sets the scan chain length in bits and the width of the data words.
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 CLR  input  1  asynchronous active-high reset.
REQ-005 START  input  1  request an operation; sampled only in IDLE.
REQ-006 CAP  input  1  operation mode, sampled with START; 0 = exchange, 1 = load-capture-unload.
REQ-007 LOAD_DATA  input  N  pattern to shift into the chain, sampled with START.
REQ-008 SCANRET  input  1  serial data returning from the tail (bit N-1) of the chain.
REQ-009 TEST  output  1  scan-enable to the chain flops; 1 = shift, 0 = functional capture.
REQ-010 SCANOUT  output  1  serial data driven to the chain SCANIN.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 UNLOAD_DATA  output  N  word collected from the chain, MSB first.

Function
REQ-014 FSM states: IDLE, SHIFT, CAPT, UNLD, FIN.
REQ-015 IDLE transitions:
- START=1: latch LOAD_DATA into shift register SR, latch CAP, clear bit counter, go to SHIFT.
- Otherwise remain in IDLE.
REQ-016 SHIFT lasts exactly N cycles with TEST=1.
- SCANOUT = SR[N-1].
- Each edge: SR <= {SR[N-2:0], SCANRET}; counter increments.
REQ-017 SHIFT exit, after N cycles: go to FIN if CAP=0, or to CAPT if CAP=1.
REQ-018 CAPT lasts exactly 1 cycle with TEST=0 and SCANOUT=0; SR holds; counter clears; next state UNLD.
REQ-019 UNLD lasts exactly N cycles with TEST=1 and SCANOUT=0 (zero fill); SR shifts in SCANRET as in SHIFT; next state FIN.
REQ-020 FIN lasts 1 cycle with DONE=1 and TEST=0; UNLOAD_DATA <= SR; next state IDLE.
REQ-021 Latency: START accepted at edge t0 gives DONE high in cycle t0+N+1 (CAP=0) or t0+2N+2 (CAP=1).
REQ-022 START is ignored while BUSY=1; no queuing.
REQ-023 START asserted in the FIN cycle is ignored; START asserted in the following IDLE cycle is accepted (back-to-back operation period N+2 for CAP=0).
REQ-024 UNLOAD_DATA holds its value from FIN until the next FIN.
REQ-025 TEST=0 in IDLE, CAPT and FIN.
REQ-026 The bit counter is ceil(log2(N+1)) bits wide; it never wraps within a state and the terminal count is N-1.

Reset
REQ-027 CLR=1 forces, asynchronously and at any time including mid-operation:
- state = IDLE
- TEST = 0, SCANOUT = 0, BUSY = 0, DONE = 0
- UNLOAD_DATA = 0, SR = 0, counter = 0
REQ-028 After CLR deasserts, the first START is accepted normally; no partial operation resumes.

Structure
REQ-029 FSM state encodings and the counter-width function belong in a shared scan package, reused by the other scan-chain blocks.
REQ-030 One sub-module is natural: scan_shreg, an N-bit parallel-load serial shift register with load and shift enables.
REQ-031 All outputs SHALL be registered; SCANOUT is taken from the SR MSB, not from combinational logic.

Verification
REQ-032 The bench chain model is an 8-flop scan chain (TEST=1 shift, TEST=0 capture of a functional word), reset to 0x00, with N=8. Required scenarios:
- Exchange: START, CAP=0, LOAD_DATA=0xA5 -> DONE at t0+9, UNLOAD_DATA=0x00, chain holds 0xA5, TEST high for exactly 8 cycles.
- Second exchange: START, CAP=0, LOAD_DATA=0x3C -> UNLOAD_DATA=0xA5, chain holds 0x3C.
- Capture: functional word 0x5A, START, CAP=1, LOAD_DATA=0xFF -> TEST low for exactly 1 cycle at t0+9, DONE at t0+18, UNLOAD_DATA=0x5A, chain holds 0x00.
- START pulses during BUSY and during FIN -> ignored, no extra DONE.
- CLR asserted in SHIFT cycle 4 -> TEST, BUSY and UNLOAD_DATA read 0 immediately; next START, CAP=0, LOAD_DATA=0x81 completes in 9 cycles.
